// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard control unit:
//   - REG_W_DEFAULT : default register-index width
//   - CNT_W         : width of the flush-length counter (FLUSH_CYCLES <= 7)
//   - hcu_state_e   : FSM state encoding (RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3)
//   - hcu_ctrl_t    : bundle of the four pipeline control signals
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_W_DEFAULT = 5;
    localparam int CNT_W         = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } hcu_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_flush;
        logic id_ex_bubble;
    } hcu_ctrl_t;

endpackage : hazard_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping. Only present when
// HAZARD_PERF_CNT_EN is defined, since nothing else instantiates it.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset, clears the count
//   en_i    : count this cycle
//   count_o : current count (WIDTH bits)
// -----------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule : sat_counter
`endif

// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
// Pipeline hazard controller: load-use stalls, branch/jump flushes of the
// fetch stage and data-memory wait stalls.
// Parameters:
//   REG_W        : register-index width
//   FLUSH_CYCLES : cycles IF_flush is held per taken branch/jump (1..7)
// Ports:
//   clk, rst             : clock (rising edge), async active-high reset
//   id_rs, id_rt         : source registers of the instruction in ID
//   ex_mem_read, ex_rt   : EX instruction is a load, and its destination
//   pc_jump, br_taken    : jump resolved / branch taken
//   mem_busy             : data memory wait request
//   PC_write, IF_ID_write, IF_flush, ID_EX_bubble : pipeline controls
//   state                : current FSM state (debug)
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   stall_cycles : cycles with PC_write=0 and IF_flush=0 (saturating)
//   flush_cycles : cycles with IF_flush=1 (saturating)
// Handshake: none; outputs are combinational from state and the current
// inputs, so the pipeline sees the decision in the same cycle.
// -----------------------------------------------------------------------------
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int REG_W        = REG_W_DEFAULT,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             pc_jump,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_flush,
    output logic             ID_EX_bubble,
    output logic [1:0]       state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_cycles
`endif
);

    // Remaining FLUSH-state cycles after the cycle that detects the redirect.
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    hcu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    hcu_ctrl_t        ctrl;
    logic             load_use;
    logic             load_use_eff;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    // The cycle after a load-use stall the load has moved on to MEM; the same
    // pair may still be visible on the inputs but must not stall again.
    assign load_use_eff = load_use && (state_q != ST_LU_STALL);

    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (state_q == ST_FLUSH) begin
            // mem_busy deliberately ignored: the flush sequence runs to completion.
            ctrl.if_flush     = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (mem_busy) begin
            // RUN, LU_STALL or MEM_WAIT: freeze everything while memory waits.
            state_d = ST_MEM_WAIT;
        end else if (pc_jump || br_taken) begin
            ctrl.if_flush     = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
            if (FLUSH_CYCLES <= 1) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                state_d = ST_FLUSH;
                cnt_d   = FLUSH_LOAD;
            end
        end else if (load_use_eff) begin
            ctrl.id_ex_bubble = 1'b1;
            state_d           = ST_LU_STALL;
        end else begin
            ctrl.pc_write    = 1'b1;
            ctrl.if_id_write = 1'b1;
            state_d          = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset gates the combinational outputs so they drop without a clock edge.
    assign PC_write     = ctrl.pc_write     && !rst;
    assign IF_ID_write  = ctrl.if_id_write  && !rst;
    assign IF_flush     = ctrl.if_flush     && !rst;
    assign ID_EX_bubble = ctrl.id_ex_bubble && !rst;
    assign state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic stall_en;
    logic flush_en;

    assign stall_en = !PC_write && !IF_flush;
    assign flush_en = IF_flush;

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (stall_en),
        .count_o (stall_cycles)
    );

    sat_counter #(.WIDTH(32)) u_flush_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (flush_en),
        .count_o (flush_cycles)
    );
`endif

endmodule : hazard_control_unit

// File: tb/tb_hazard_control_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_control_unit
// Table of per-cycle vectors plus hand-written reset and perf-counter
// sequences. Expected {state, PC_write, IF_ID_write, IF_flush, ID_EX_bubble}
// is pushed when a vector is driven and popped when outputs are sampled.
// -----------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam int REG_W = 5;
    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_LU  = 2'd1;
    localparam logic [1:0] S_FL  = 2'd2;
    localparam logic [1:0] S_MW  = 2'd3;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             ex_mem_read, pc_jump, br_taken, mem_busy;
    logic             PC_write, IF_ID_write, IF_flush, ID_EX_bubble;
    logic [1:0]       state;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]      stall_cycles, flush_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    logic [5:0] exp_q[$];

    typedef struct {
        logic [REG_W-1:0] rs, rt, exrt;
        logic             mr, pj, bt, mb;
        logic [1:0]       st;
        logic [3:0]       ctl;   // {PC_write, IF_ID_write, IF_flush, ID_EX_bubble}
    } vec_t;

    vec_t vecs[$];

    hazard_control_unit #(
        .REG_W        (REG_W),
        .FLUSH_CYCLES (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .pc_jump      (pc_jump),
        .br_taken     (br_taken),
        .mem_busy     (mem_busy),
        .PC_write     (PC_write),
        .IF_ID_write  (IF_ID_write),
        .IF_flush     (IF_flush),
        .ID_EX_bubble (ID_EX_bubble),
        .state        (state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic vec_t mk(input logic [REG_W-1:0] rs, rt, exrt,
                                input logic mr, pj, bt, mb,
                                input logic [1:0] st, input logic [3:0] ctl);
        vec_t v;
        v.rs = rs; v.rt = rt; v.exrt = exrt;
        v.mr = mr; v.pj = pj; v.bt = bt; v.mb = mb;
        v.st = st; v.ctl = ctl;
        return v;
    endfunction

    // Irrelevant register indices: no load in EX, so they must not matter.
    function automatic vec_t idle(input logic mb, input logic pj,
                                  input logic [1:0] st, input logic [3:0] ctl);
        return mk(REG_W'($urandom_range(0, 31)), REG_W'($urandom_range(0, 31)),
                  REG_W'($urandom_range(0, 31)), 1'b0, pj, 1'b0, mb, st, ctl);
    endfunction

    task automatic drive(input vec_t v);
        id_rs       = v.rs;
        id_rt       = v.rt;
        ex_rt       = v.exrt;
        ex_mem_read = v.mr;
        pc_jump     = v.pj;
        br_taken    = v.bt;
        mem_busy    = v.mb;
        exp_q.push_back({v.st, v.ctl});
    endtask

    task automatic compare_out(input string name);
        logic [5:0] got;
        logic [5:0] exp;
        got = {state, PC_write, IF_ID_write, IF_flush, ID_EX_bubble};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got=%b", name, got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL %s: got {state,pcw,ifidw,flush,bubble}=%b expected=%b",
                         name, got, exp);
            end
        end
    endtask

    task automatic check_no_overlap(input string name);
        checks++;
        if (IF_flush && PC_write) begin
            failures++;
            $display("FAIL %s: IF_flush and PC_write both 1", name);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // One clock cycle: drive just after the rising edge, sample at the falling edge.
    task automatic step(input vec_t v, input string name);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        compare_out(name);
        check_no_overlap(name);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive(idle(1'b0, 1'b0, S_RUN, 4'b0000));
        #3;
        compare_out("reset_state");
        @(negedge clk);
        rst = 1'b0;

        // Vector table (FLUSH_CYCLES = 3)
        vecs.push_back(idle(1'b0, 1'b0, S_RUN, 4'b1100));                                // 0 idle
        vecs.push_back(mk(5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN, 4'b0001));     // 1 load-use rs
        vecs.push_back(mk(5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, S_LU,  4'b1100));     // 2 no re-stall
        vecs.push_back(mk(5'd3, 5'd9, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, S_RUN, 4'b1100));     // 3
        vecs.push_back(mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN, 4'b1100));     // 4 r0 load
        vecs.push_back(mk(5'd4, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN, 4'b0001));     // 5 load-use rt
        vecs.push_back(mk(5'd4, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, S_LU,  4'b0011));     // 6 branch in LU
        vecs.push_back(idle(1'b1, 1'b0, S_FL,  4'b0011));                                // 7 busy ignored
        vecs.push_back(idle(1'b0, 1'b0, S_FL,  4'b0011));                                // 8
        vecs.push_back(idle(1'b0, 1'b0, S_RUN, 4'b1100));                                // 9
        vecs.push_back(idle(1'b1, 1'b1, S_RUN, 4'b0000));                                // 10 busy+jump
        vecs.push_back(idle(1'b1, 1'b1, S_MW,  4'b0000));                                // 11
        vecs.push_back(idle(1'b1, 1'b1, S_MW,  4'b0000));                                // 12
        vecs.push_back(idle(1'b1, 1'b1, S_MW,  4'b0000));                                // 13
        vecs.push_back(idle(1'b0, 1'b1, S_MW,  4'b0011));                                // 14 release
        vecs.push_back(idle(1'b0, 1'b0, S_FL,  4'b0011));                                // 15
        vecs.push_back(idle(1'b0, 1'b0, S_FL,  4'b0011));                                // 16
        vecs.push_back(idle(1'b0, 1'b0, S_RUN, 4'b1100));                                // 17
        vecs.push_back(mk(5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, S_RUN, 4'b0000));     // 18 busy wins
        vecs.push_back(mk(5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, S_MW,  4'b0001));     // 19 load-use on release
        vecs.push_back(mk(5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, S_LU,  4'b1100));     // 20
        vecs.push_back(mk(5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, S_RUN, 4'b0011));     // 21 branch beats load-use
        vecs.push_back(idle(1'b0, 1'b0, S_FL,  4'b0011));                                // 22
        vecs.push_back(idle(1'b0, 1'b0, S_FL,  4'b0011));                                // 23
        vecs.push_back(idle(1'b0, 1'b0, S_RUN, 4'b1100));                                // 24

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted during the second flush cycle (first FLUSH-state cycle)
        step(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN, 4'b0011), "rstseq_branch");
        @(posedge clk);
        #1;
        drive(idle(1'b0, 1'b0, S_FL, 4'b0011));
        #1;
        compare_out("rstseq_flush2");
        rst = 1'b1;
        exp_q.push_back({S_RUN, 4'b0000});
        #1;
        compare_out("rstseq_async_zero");
        #1;
        rst = 1'b0;
        step(idle(1'b0, 1'b0, S_RUN, 4'b1100), "rstseq_after1");
        step(idle(1'b0, 1'b0, S_RUN, 4'b1100), "rstseq_after2");

`ifdef HAZARD_PERF_CNT_EN
        pulse_reset();
        step(idle(1'b0, 1'b0, S_RUN, 4'b1100), "perf_idle");
        step(mk(5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, S_RUN, 4'b0001), "perf_lu");
        step(mk(5'd3, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, S_LU,  4'b1100), "perf_lu_stall");
        step(idle(1'b0, 1'b0, S_RUN, 4'b1100), "perf_idle2");
        step(mk(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, S_RUN, 4'b0011), "perf_br");
        step(idle(1'b0, 1'b0, S_FL,  4'b0011), "perf_fl2");
        step(idle(1'b0, 1'b0, S_FL,  4'b0011), "perf_fl3");
        step(idle(1'b0, 1'b0, S_RUN, 4'b1100), "perf_run");
        check32("perf_stall_cycles", stall_cycles, 32'd1);
        check32("perf_flush_cycles", flush_cycles, 32'd3);
`endif

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hazard_control_unit
